// File: rtl/cpu_pkg.sv
// Shared CPU-side types: boot loader state encoding and the default frame start byte.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_e;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

endpackage

// File: rtl/instr_loader.sv
// Byte-stream boot loader: frames MAGIC/LEN_LO/LEN_HI/data into LE 32-bit instruction writes.
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHK state).
module instr_loader
  import cpu_pkg::*;
#(
  parameter int         MAX_WORDS      = 1024,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] MAGIC          = LOADER_MAGIC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        wr_instr_en_o,
  output logic [31:0] wr_instr_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int NW_W  = $clog2(MAX_WORDS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam loader_state_e LEN_END = CHK;
`else
  localparam loader_state_e LEN_END = DONE;
`endif

  loader_state_e    state, state_nxt;
  logic [7:0]       len_lo;
  logic [15:0]      len16;
  logic [NW_W-1:0]  num_words, word_cnt;
  logic [1:0]       byte_idx;
  logic [23:0]      shift;
  logic [TMO_W-1:0] tmo_cnt;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic accept, is_magic, in_frame, tmo_hit, last_word, too_big;

  assign accept    = rx_valid_i && rx_ready_o;
  assign is_magic  = (rx_data_i == MAGIC);
  assign in_frame  = state inside {LEN_LO, LEN_HI, DATA, CHK};
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign len16     = {rx_data_i, len_lo};
  assign too_big   = ({1'b0, len16} > 17'(MAX_WORDS));
  assign last_word = ((word_cnt + NW_W'(1)) == num_words);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (accept && is_magic) state_nxt = LEN_LO;
      LEN_LO:          if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len16 == 16'd0) state_nxt = LEN_END;
          else if (too_big)   state_nxt = ERR;
          else                state_nxt = DATA;
        end
      end
      DATA: if (accept && byte_idx == 2'd3 && last_word) state_nxt = LEN_END;
`ifdef INSTR_LOADER_CHECKSUM_EN
      CHK:  if (accept) state_nxt = (rx_data_i == csum) ? DONE : ERR;
`endif
      default: state_nxt = IDLE;
    endcase
    // a stalled source inside a frame aborts the load
    if (in_frame && !accept && tmo_hit) state_nxt = ERR;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_ready_o    <= 1'b0;
      wr_instr_en_o <= 1'b0;
      wr_instr_o    <= '0;
      cpu_rst_o     <= 1'b1;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      len_lo        <= '0;
      num_words     <= '0;
      word_cnt      <= '0;
      byte_idx      <= '0;
      shift         <= '0;
      tmo_cnt       <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      rx_ready_o    <= 1'b1;
      wr_instr_en_o <= 1'b0;
      tmo_cnt       <= (in_frame && !accept && !tmo_hit) ? tmo_cnt + TMO_W'(1) : '0;
      if (accept) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (is_magic) begin
              cpu_rst_o <= 1'b1;
              done_o    <= 1'b0;
              err_o     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
              csum      <= '0;
`endif
            end
          end
          LEN_LO: begin
            len_lo <= rx_data_i;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum   <= csum ^ rx_data_i;
`endif
          end
          LEN_HI: begin
            num_words <= NW_W'(len16);
            word_cnt  <= '0;
            byte_idx  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum      <= csum ^ rx_data_i;
`endif
          end
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
            // bytes arrive LSB first, so shift in from the top
            shift    <= {rx_data_i, shift[23:8]};
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data_i;
`endif
            if (byte_idx == 2'd3) begin
              wr_instr_o    <= {rx_data_i, shift};
              wr_instr_en_o <= 1'b1;
              word_cnt      <= word_cnt + NW_W'(1);
            end
          end
          default: ;
        endcase
      end
      if (state_nxt == DONE && state != DONE) begin
        cpu_rst_o <= 1'b0;
        done_o    <= 1'b1;
      end
      if (state_nxt == ERR && state != ERR) err_o <= 1'b1;
    end
  end

endmodule
